// File: rtl/mipsfpga_lcd_spi_pkg.sv
// Shared definitions for the AHB-Lite LCD SPI transmitter: register map, field
// positions, shift FSM encoding and reset defaults.
package mipsfpga_lcd_spi_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_LEVEL_LSB = 4;

   localparam int CTRL_DIV_MSB = 7;
   localparam int CTRL_IRQ_EN  = 8;
   localparam int DATA_RS      = 8;

   localparam int DIV_RESET_DEFAULT = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } spi_state_e;

endpackage

// File: rtl/mipsfpga_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally and a
// push is accepted while full only if a pop happens in the same cycle.
module mipsfpga_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DEPTH_C);
   assign level_o = count_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mipsfpga_ahb_lcd_spi.sv
// AHB-Lite slave feeding a byte FIFO into an SPI shifter for an LCD panel.
// Define MIPSFPGA_LCD_SPI_IRQ_EN to add the lcd_irq output and CTRL[8] enable.
module mipsfpga_ahb_lcd_spi
   import mipsfpga_lcd_spi_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_RESET  = DIV_RESET_DEFAULT
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic        lcd_sck,
   output logic        lcd_sdo,
   output logic        lcd_rs
`ifdef MIPSFPGA_LCD_SPI_IRQ_EN
   ,
   output logic        lcd_irq
`endif
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [LW-1:0] fifo_level;
   logic [8:0]    fifo_rdata;
   logic          fifo_full, fifo_empty, fifo_pop, busy;
   logic          dp_valid_q, dp_write_q;
   logic [1:0]    dp_addr_q;
   logic          wr_data, wr_status, wr_ctrl;
   logic          ovf_q, ovf_d;
   logic [7:0]    div_q, div_cur_q, hcnt_q, shreg_q;
   logic [3:0]    hp_q, lvl4;
   logic [4:0]    lvl_ext;
   logic          sck_q, sdo_q, rs_q;
   spi_state_e    state_q;
   logic          unused_bits;

   assign HREADY      = 1'b1;
   assign HRESP       = 1'b0;
   assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:9]};

   // Zero-wait slave: address phase is latched, the access happens one cycle later.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_addr_q  <= REG_DATA;
      end else begin
         dp_valid_q <= HSEL && HTRANS[1];
         dp_write_q <= HWRITE;
         dp_addr_q  <= HADDR[3:2];
      end
   end

   assign wr_data   = dp_valid_q && dp_write_q && (dp_addr_q == REG_DATA);
   assign wr_status = dp_valid_q && dp_write_q && (dp_addr_q == REG_STATUS);
   assign wr_ctrl   = dp_valid_q && dp_write_q && (dp_addr_q == REG_CTRL);

   mipsfpga_sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (HCLK),
      .rst_ni  (HRESETn),
      .push_i  (wr_data),
      .wdata_i (HWDATA[8:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;
   assign busy     = (state_q != S_IDLE) || !fifo_empty;
   assign lvl_ext  = 5'(fifo_level);
   assign lvl4     = (lvl_ext > 5'd15) ? 4'hF : lvl_ext[3:0];

   // A dropped write sets overflow even when software clears it in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_status && HWDATA[ST_OVF]) ovf_d = 1'b0;
      if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
   end

`ifdef MIPSFPGA_LCD_SPI_IRQ_EN
   logic irq_en_q, irq_q;
   assign lcd_irq = irq_q;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ovf_q <= 1'b0;
         div_q <= 8'(DIV_RESET);
`ifdef MIPSFPGA_LCD_SPI_IRQ_EN
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
`endif
      end else begin
         ovf_q <= ovf_d;
         if (wr_ctrl) div_q <= HWDATA[CTRL_DIV_MSB:0];
`ifdef MIPSFPGA_LCD_SPI_IRQ_EN
         if (wr_ctrl) irq_en_q <= HWDATA[CTRL_IRQ_EN];
         irq_q <= irq_en_q && !busy;
`endif
      end
   end

   always_comb begin
      HRDATA = '0;
      if (dp_valid_q && !dp_write_q) begin
         case (dp_addr_q)
            REG_STATUS: begin
               HRDATA[ST_BUSY]            = busy;
               HRDATA[ST_FULL]            = fifo_full;
               HRDATA[ST_EMPTY]           = fifo_empty;
               HRDATA[ST_OVF]             = ovf_q;
               HRDATA[ST_LEVEL_LSB +: 4]  = lvl4;
            end
            REG_CTRL: begin
               HRDATA[CTRL_DIV_MSB:0] = div_q;
`ifdef MIPSFPGA_LCD_SPI_IRQ_EN
               HRDATA[CTRL_IRQ_EN]    = irq_en_q;
`endif
            end
            default: ;
         endcase
      end
   end

   // Even half-periods end with SCK rising, odd ones with SCK falling and the next bit.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= S_IDLE;
         hcnt_q    <= '0;
         hp_q      <= '0;
         shreg_q   <= '0;
         div_cur_q <= '0;
         sck_q     <= 1'b0;
         sdo_q     <= 1'b0;
         rs_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  state_q   <= S_SHIFT;
                  shreg_q   <= {fifo_rdata[6:0], 1'b0};
                  sdo_q     <= fifo_rdata[7];
                  rs_q      <= fifo_rdata[DATA_RS];
                  div_cur_q <= div_q;
                  hcnt_q    <= '0;
                  hp_q      <= '0;
               end
            end
            S_SHIFT: begin
               if (hcnt_q == div_cur_q) begin
                  hcnt_q <= '0;
                  hp_q   <= hp_q + 4'd1;
                  if (!hp_q[0]) begin
                     sck_q <= 1'b1;
                  end else begin
                     sck_q   <= 1'b0;
                     sdo_q   <= shreg_q[7];
                     shreg_q <= {shreg_q[6:0], 1'b0};
                     if (hp_q == 4'd15) state_q <= S_GAP;
                  end
               end else begin
                  hcnt_q <= hcnt_q + 8'd1;
               end
            end
            S_GAP: begin
               if (hcnt_q == div_cur_q) begin
                  hcnt_q  <= '0;
                  state_q <= S_IDLE;
               end else begin
                  hcnt_q <= hcnt_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign lcd_sck = sck_q;
   assign lcd_sdo = sdo_q;
   assign lcd_rs  = rs_q;

endmodule

// File: tb/tb_mipsfpga_ahb_lcd_spi.sv
// Directed bench for mipsfpga_ahb_lcd_spi: expected SPI bits, rs and SCK spacing
// are queued as bytes are written and checked on every rising edge of lcd_sck.
`timescale 1ns/1ps
module tb_mipsfpga_ahb_lcd_spi;

   localparam logic [3:0] A_DATA   = 4'h0;
   localparam logic [3:0] A_STATUS = 4'h4;
   localparam logic [3:0] A_CTRL   = 4'h8;
   localparam logic [3:0] A_NONE   = 4'hC;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'd2;
   logic [31:0] HWDATA = '0;
   logic [31:0] HRDATA;
   logic        HREADY, HRESP, lcd_sck, lcd_sdo, lcd_rs;
`ifdef MIPSFPGA_LCD_SPI_IRQ_EN
   logic        lcd_irq;
   logic        irq_prev = 1'b0;
   int          irq_rises = 0;
   int          irq_rise_cyc = 0;
`endif

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          rise_cnt = 0;
   int          last_rise = 0;
   int          base;
   logic        sck_prev = 1'b0;
   logic [23:0] exp_q[$];
   logic [23:0] mon_e;
   logic [31:0] rd0, rd1;

   always #5 HCLK = ~HCLK;

   mipsfpga_ahb_lcd_spi #(.FIFO_DEPTH(8), .DIV_RESET(4)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .HSEL    (HSEL),
      .HADDR   (HADDR),
      .HTRANS  (HTRANS),
      .HWRITE  (HWRITE),
      .HSIZE   (HSIZE),
      .HWDATA  (HWDATA),
      .HRDATA  (HRDATA),
      .HREADY  (HREADY),
      .HRESP   (HRESP),
      .lcd_sck (lcd_sck),
      .lcd_sdo (lcd_sdo),
      .lcd_rs  (lcd_rs)
`ifdef MIPSFPGA_LCD_SPI_IRQ_EN
      ,
      .lcd_irq (lcd_irq)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic ahb_write(input logic [3:0] off, input logic [31:0] d);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, off};
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
   endtask

   task automatic ahb_read(input logic [3:0] off, output logic [31:0] d);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, off};
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
   endtask

   // Two pipelined reads of the same register on consecutive cycles.
   task automatic ahb_read2(input logic [3:0] off, output logic [31:0] d0, output logic [31:0] d1);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, off};
      @(negedge HCLK);
      d0 = HRDATA;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      d1 = HRDATA;
   endtask

   // Entry: [23:8] cycles since previous SCK rise (0 = unchecked), [1] rs, [0] sdo.
   task automatic push_byte(input logic [8:0] v, input int div, input int first_gap);
      logic [15:0] gap;
      for (int i = 0; i < 8; i++) begin
         gap = (i == 0) ? 16'(first_gap) : 16'(2 * (div + 1));
         exp_q.push_back({gap, 6'b0, v[8], v[7 - i]});
      end
   endtask

   task automatic wait_drained(input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge HCLK);
      check("bytes_drained", 32'(exp_q.size()), 0);
   endtask

   always @(posedge HCLK) begin
      #1;
      cyc++;
      if (lcd_sck && !sck_prev) begin
         rise_cnt++;
         check("sck_rise_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sdo_bit", 32'(lcd_sdo), 32'(mon_e[0]));
            check("rs_bit", 32'(lcd_rs), 32'(mon_e[1]));
            if (mon_e[23:8] != 16'd0) check("sck_spacing", 32'(cyc - last_rise), 32'(mon_e[23:8]));
            last_rise = cyc;
         end
      end
      sck_prev = lcd_sck;
`ifdef MIPSFPGA_LCD_SPI_IRQ_EN
      if (lcd_irq && !irq_prev) begin
         irq_rises++;
         irq_rise_cyc = cyc;
      end
      irq_prev = lcd_irq;
`endif
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values, observed while reset is held.
      #12;
      check("rst_sck", 32'(lcd_sck), 0);
      check("rst_sdo", 32'(lcd_sdo), 0);
      check("rst_rs", 32'(lcd_rs), 0);
      check("rst_hrdata", HRDATA, 0);
      check("hready", 32'(HREADY), 1);
      check("hresp", 32'(HRESP), 0);
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      ahb_read(A_STATUS, rd0);
      check("status_after_reset", rd0, 32'h4);
      ahb_read(A_CTRL, rd0);
      check("ctrl_after_reset", rd0, 32'h4);
      ahb_read(A_NONE, rd0);
      check("unmapped_read", rd0, 0);

      // Single byte at DIV=1, then busy timing around the end of the gap.
      ahb_write(A_CTRL, 32'h1);
      base = rise_cnt;
      push_byte(9'h1A5, 1, 0);
      ahb_write(A_DATA, 32'h1A5);
      repeat (33) @(negedge HCLK);
      ahb_read2(A_STATUS, rd0, rd1);
      check("status_busy_last_gap_cycle", rd0, 32'h5);
      check("status_idle_after_34", rd1, 32'h4);
      check("single_byte_rises", 32'(rise_cnt - base), 8);
      check("single_byte_drained", 32'(exp_q.size()), 0);
      ahb_read(A_DATA, rd0);
      check("data_reads_zero", rd0, 0);

      // Divisor change while byte 1 is in flight.
      push_byte(9'h03C, 1, 0);
      push_byte(9'h1C3, 0, 6);
      ahb_write(A_DATA, 32'h03C);
      ahb_write(A_DATA, 32'h1C3);
      ahb_write(A_CTRL, 32'h0);
      wait_drained(400);
      repeat (10) @(negedge HCLK);
      ahb_read(A_STATUS, rd0);
      check("status_after_div_change", rd0, 32'h4);
      ahb_read(A_CTRL, rd0);
      check("ctrl_div_zero", rd0, 32'h0);

`ifdef MIPSFPGA_LCD_SPI_IRQ_EN
      ahb_write(A_CTRL, 32'h104);
      ahb_read(A_CTRL, rd0);
      check("ctrl_irq_en_readback", rd0, 32'h104);
      repeat (2) @(negedge HCLK);
      check("irq_idle_high", 32'(lcd_irq), 1);
      irq_rises = 0;
      push_byte(9'h155, 4, 0);
      push_byte(9'h0AA, 4, 16);
      ahb_write(A_DATA, 32'h155);
      ahb_write(A_DATA, 32'h0AA);
      wait_drained(400);
      check("irq_low_during_tail", 32'(lcd_irq), 0);
      for (int i = 0; i < 40 && !lcd_irq; i++) @(negedge HCLK);
      check("irq_single_rise", 32'(irq_rises), 1);
      check("irq_after_last_gap", 32'(irq_rise_cyc - last_rise), 11);
`else
      ahb_write(A_CTRL, 32'h104);
      ahb_read(A_CTRL, rd0);
      check("ctrl_bit8_ignored", rd0, 32'h004);
`endif

      // Stall the shifter with a 0xFF byte, then fill and overflow the FIFO.
      ahb_write(A_CTRL, 32'hFF);
      base = rise_cnt;
      push_byte(9'h1FF, 255, 0);
      ahb_write(A_DATA, 32'h1FF);
      for (int i = 0; i < 9; i++) ahb_write(A_DATA, 32'(i));
      ahb_read(A_STATUS, rd0);
      check("status_full_overflow", rd0, 32'h8B);
      ahb_write(A_STATUS, 32'h8);
      ahb_read(A_STATUS, rd0);
      check("status_overflow_cleared", rd0, 32'h83);

      // Reset during bit 4 of the stalled byte.
      for (int i = 0; i < 3000 && rise_cnt < base + 4; i++) @(negedge HCLK);
      check("reached_bit4", 32'(rise_cnt - base), 4);
      #2;
      check("sck_high_before_reset", 32'(lcd_sck), 1);
      check("sdo_high_before_reset", 32'(lcd_sdo), 1);
      HRESETn = 1'b0;
      #1;
      check("reset_sck_drop", 32'(lcd_sck), 0);
      check("reset_sdo_drop", 32'(lcd_sdo), 0);
      check("reset_rs_drop", 32'(lcd_rs), 0);
      exp_q.delete();
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      base = rise_cnt;
      repeat (100) @(negedge HCLK);
      check("no_sck_after_reset", 32'(rise_cnt - base), 0);
      ahb_read(A_STATUS, rd0);
      check("status_empty_after_reset", rd0, 32'h4);
      ahb_read(A_CTRL, rd0);
      check("ctrl_reset_after_abort", rd0, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
